stopwatch_cmd_ctrl: RTL and testbench

STOPWATCH_CMD_CTRL -- requirements
Module: stopwatch_cmd_ctrl

---
 rtl/stopwatch_pkg.sv | 31 +++
 rtl/btn_edge_det.sv | 26 ++
 rtl/stopwatch_cmd_ctrl.sv | 145 ++++++++++++++
 tb/tb_stopwatch_cmd_ctrl.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch/watch command controller.
package stopwatch_pkg;

    typedef enum logic [2:0] {
        StSwStop,
        StSwRun,
        StSwClear,
        StWRun,
        StWSet
    } state_e;

    typedef enum logic [2:0] {
        EvNone,
        EvClear,
        EvRun,
        EvMode,
        EvDigit,
        EvUp
    } event_e;

    localparam logic [7:0] CMD_RUN   = 8'h72;  // 'r'
    localparam logic [7:0] CMD_CLEAR = 8'h63;  // 'c'
    localparam logic [7:0] CMD_MODE  = 8'h6d;  // 'm'
    localparam logic [7:0] CMD_DIGIT = 8'h64;  // 'd'
    localparam logic [7:0] CMD_UP    = 8'h75;  // 'u'

    localparam logic [1:0] SEC  = 2'd0;
    localparam logic [1:0] MIN  = 2'd1;
    localparam logic [1:0] HOUR = 2'd2;

endpackage

// File: rtl/btn_edge_det.sv
// Registered rising-edge detector for one debounced button level.
// The first cycle after reset primes both history flops so a held button gives no edge.
module btn_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic btn_i,
    output logic edge_o
);

    logic btn_q, prev_q, armed_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_q   <= 1'b0;
            prev_q  <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            armed_q <= 1'b1;
            btn_q   <= btn_i;
            prev_q  <= armed_q ? btn_q : btn_i;
        end
    end

    assign edge_o = btn_q & ~prev_q;

endmodule

// File: rtl/stopwatch_cmd_ctrl.sv
// Stopwatch / watch-set command controller merging board buttons and PC commands.
// Define PC_CMD_EN to compile in the PC command path; otherwise pc_ready/o_cmd_err are tied 0.
module stopwatch_cmd_ctrl
    import stopwatch_pkg::*;
#(
    parameter int unsigned DIGIT_CNT = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_run,
    input  logic       btn_clear,
    input  logic       btn_mode,
    input  logic       btn_digit,
    input  logic       btn_up,
    input  logic       pc_valid,
    input  logic [7:0] pc_cmd,
    output logic       pc_ready,
    output logic       o_mode,
    output logic       o_sw_run,
    output logic       o_sw_clear,
    output logic       o_set_en,
    output logic [1:0] o_digit_sel,
    output logic       o_inc,
    output logic       o_cmd_err
);

    localparam logic [1:0] LastDigit = 2'(DIGIT_CNT - 1);

    state_e     state_q, state_d;
    logic [1:0] digit_sel_q, digit_sel_d;
    logic       inc_q, inc_d;
    logic       cmd_err_q, cmd_err_d;
    event_e     board_ev, ev;
    logic       edge_run, edge_clear, edge_mode, edge_digit, edge_up, board_any;

    btn_edge_det u_edge_run   (.clk(clk), .rst(rst), .btn_i(btn_run),   .edge_o(edge_run));
    btn_edge_det u_edge_clear (.clk(clk), .rst(rst), .btn_i(btn_clear), .edge_o(edge_clear));
    btn_edge_det u_edge_mode  (.clk(clk), .rst(rst), .btn_i(btn_mode),  .edge_o(edge_mode));
    btn_edge_det u_edge_digit (.clk(clk), .rst(rst), .btn_i(btn_digit), .edge_o(edge_digit));
    btn_edge_det u_edge_up    (.clk(clk), .rst(rst), .btn_i(btn_up),    .edge_o(edge_up));

    assign board_any = edge_run | edge_clear | edge_mode | edge_digit | edge_up;

    always_comb begin
        board_ev = EvNone;
        if (edge_clear)      board_ev = EvClear;
        else if (edge_run)   board_ev = EvRun;
        else if (edge_mode)  board_ev = EvMode;
        else if (edge_digit) board_ev = EvDigit;
        else if (edge_up)    board_ev = EvUp;
    end

`ifdef PC_CMD_EN
    logic   pc_acc, pc_unknown;
    event_e pc_ev;

    assign pc_ready = ~rst & ~board_any & (state_q != StSwClear);
    assign pc_acc   = pc_valid & pc_ready;

    always_comb begin
        pc_ev      = EvNone;
        pc_unknown = 1'b0;
        case (pc_cmd)
            CMD_RUN:   pc_ev = EvRun;
            CMD_CLEAR: pc_ev = EvClear;
            CMD_MODE:  pc_ev = EvMode;
            CMD_DIGIT: pc_ev = EvDigit;
            CMD_UP:    pc_ev = EvUp;
            default:   pc_unknown = 1'b1;
        endcase
    end

    // pc_acc implies no board edge, so the board event is EvNone whenever PC wins.
    assign ev        = pc_acc ? pc_ev : board_ev;
    assign cmd_err_d = pc_acc & pc_unknown;
`else
    logic unused_pc;
    assign unused_pc = ^{pc_valid, pc_cmd};
    assign pc_ready  = 1'b0;
    assign ev        = board_ev;
    assign cmd_err_d = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StSwStop;
            digit_sel_q <= SEC;
            inc_q       <= 1'b0;
            cmd_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            digit_sel_q <= digit_sel_d;
            inc_q       <= inc_d;
            cmd_err_q   <= cmd_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        digit_sel_d = digit_sel_q;
        inc_d       = 1'b0;
        unique case (state_q)
            StSwStop: begin
                if (ev == EvRun)        state_d = StSwRun;
                else if (ev == EvClear) state_d = StSwClear;
                else if (ev == EvMode)  state_d = StWRun;
            end
            StSwRun: begin
                if (ev == EvRun) state_d = StSwStop;
            end
            StSwClear: state_d = StSwStop;
            StWRun: begin
                if (ev == EvMode) begin
                    state_d = StSwStop;
                end else if (ev == EvDigit) begin
                    state_d     = StWSet;
                    digit_sel_d = SEC;
                end
            end
            StWSet: begin
                if (ev == EvDigit) begin
                    digit_sel_d = (digit_sel_q == LastDigit) ? SEC : digit_sel_q + 2'd1;
                end else if (ev == EvUp) begin
                    inc_d = 1'b1;
                end else if (ev == EvRun) begin
                    state_d = StWRun;
                end else if (ev == EvMode) begin
                    state_d = StSwStop;
                end
            end
            default: state_d = StSwStop;
        endcase
    end

    always_comb begin
        o_mode      = (state_q == StWRun) || (state_q == StWSet);
        o_sw_run    = (state_q == StSwRun);
        o_sw_clear  = (state_q == StSwClear);
        o_set_en    = (state_q == StWSet);
        o_digit_sel = digit_sel_q;
        o_inc       = inc_q;
        o_cmd_err   = cmd_err_q;
    end

endmodule

// File: tb/tb_stopwatch_cmd_ctrl.sv
// Directed self-checking bench for stopwatch_cmd_ctrl; outs = {mode,run,clr,set,sel[1:0],inc,err}.
module tb_stopwatch_cmd_ctrl;

`ifdef PC_CMD_EN
    localparam logic PcEn = 1'b1;
`else
    localparam logic PcEn = 1'b0;
`endif
    localparam logic [4:0] B_CLR = 5'b10000, B_RUN = 5'b01000, B_MODE = 5'b00100;
    localparam logic [4:0] B_DIG = 5'b00010, B_UP = 5'b00001;

    logic       clk, rst;
    logic       btn_run, btn_clear, btn_mode, btn_digit, btn_up;
    logic       pc_valid;
    logic [7:0] pc_cmd;
    logic       pc_ready, o_mode, o_sw_run, o_sw_clear, o_set_en, o_inc, o_cmd_err;
    logic [1:0] o_digit_sel;
    logic [7:0] outs;
    int         vectors, miscompares;

    assign outs = {o_mode, o_sw_run, o_sw_clear, o_set_en, o_digit_sel, o_inc, o_cmd_err};

    stopwatch_cmd_ctrl #(.DIGIT_CNT(3)) dut (
        .clk(clk), .rst(rst),
        .btn_run(btn_run), .btn_clear(btn_clear), .btn_mode(btn_mode),
        .btn_digit(btn_digit), .btn_up(btn_up),
        .pc_valid(pc_valid), .pc_cmd(pc_cmd), .pc_ready(pc_ready),
        .o_mode(o_mode), .o_sw_run(o_sw_run), .o_sw_clear(o_sw_clear),
        .o_set_en(o_set_en), .o_digit_sel(o_digit_sel), .o_inc(o_inc),
        .o_cmd_err(o_cmd_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One-cycle press; on return the event has reached the registered outputs.
    task automatic press(input logic [4:0] m);
        {btn_clear, btn_run, btn_mode, btn_digit, btn_up} = m;
        tick();
        {btn_clear, btn_run, btn_mode, btn_digit, btn_up} = 5'b0;
        tick();
    endtask

    task automatic pc_send(input logic [7:0] c);
        pc_valid = 1'b1;
        pc_cmd   = c;
        tick();
        pc_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        vectors++; if (outs !== 8'b0000_0000) begin miscompares++;
            $display("FAIL reset_outs: got %b want %b", outs, 8'b0000_0000); end
        vectors++; if (pc_ready !== 1'b0) begin miscompares++;
            $display("FAIL reset_ready: got %b want %b", pc_ready, 1'b0); end
        rst = 1'b0;
        tick();
        vectors++; if (pc_ready !== PcEn) begin miscompares++;
            $display("FAIL idle_ready: got %b want %b", pc_ready, PcEn); end
    endtask

    task automatic test_run();
        btn_run = 1'b1;
        tick();
        btn_run = 1'b0;
        vectors++; if (outs !== 8'b0000_0000) begin miscompares++;
            $display("FAIL run_1clk: got %b want %b", outs, 8'b0000_0000); end
        tick();
        vectors++; if (outs !== 8'b0100_0000) begin miscompares++;
            $display("FAIL run_2clk: got %b want %b", outs, 8'b0100_0000); end
        press(B_RUN);
        vectors++; if (outs !== 8'b0000_0000) begin miscompares++;
            $display("FAIL run_stop: got %b want %b", outs, 8'b0000_0000); end
    endtask

    task automatic test_clear();
        press(B_CLR);
        vectors++; if (outs !== 8'b0010_0000) begin miscompares++;
            $display("FAIL clr_pulse: got %b want %b", outs, 8'b0010_0000); end
        vectors++; if (pc_ready !== 1'b0) begin miscompares++;
            $display("FAIL clr_ready: got %b want %b", pc_ready, 1'b0); end
        tick();
        vectors++; if (outs !== 8'b0000_0000) begin miscompares++;
            $display("FAIL clr_end: got %b want %b", outs, 8'b0000_0000); end
        press(B_RUN);
        press(B_CLR);
        vectors++; if (outs !== 8'b0100_0000) begin miscompares++;
            $display("FAIL clr_in_run: got %b want %b", outs, 8'b0100_0000); end
        tick();
        vectors++; if (outs !== 8'b0100_0000) begin miscompares++;
            $display("FAIL clr_in_run2: got %b want %b", outs, 8'b0100_0000); end
        press(B_RUN);
        press(B_CLR | B_RUN);
        vectors++; if (outs !== 8'b0010_0000) begin miscompares++;
            $display("FAIL prio_clr_run: got %b want %b", outs, 8'b0010_0000); end
        tick();
        press(B_MODE | B_DIG);
        vectors++; if (outs !== 8'b1000_0000) begin miscompares++;
            $display("FAIL prio_mode_dig: got %b want %b", outs, 8'b1000_0000); end
        press(B_MODE);
        vectors++; if (outs !== 8'b0000_0000) begin miscompares++;
            $display("FAIL prio_back: got %b want %b", outs, 8'b0000_0000); end
    endtask

    task automatic test_level();
        btn_mode = 1'b1;
        repeat (5) tick();
        vectors++; if (outs !== 8'b1000_0000) begin miscompares++;
            $display("FAIL level_held: got %b want %b", outs, 8'b1000_0000); end
        btn_mode = 1'b0;
        repeat (2) tick();
        vectors++; if (outs !== 8'b1000_0000) begin miscompares++;
            $display("FAIL level_fall: got %b want %b", outs, 8'b1000_0000); end
        press(B_MODE);
        vectors++; if (outs !== 8'b0000_0000) begin miscompares++;
            $display("FAIL level_back: got %b want %b", outs, 8'b0000_0000); end
    endtask

    task automatic test_watch();
        logic [4:0] seq_btn [12];
        logic [7:0] seq_exp [12];
        seq_btn = '{B_MODE, B_DIG, B_DIG, B_DIG, B_DIG, B_UP, B_CLR, B_DIG, B_RUN, B_UP,
                    B_DIG, B_MODE};
        seq_exp = '{8'b1000_0000, 8'b1001_0000, 8'b1001_0100, 8'b1001_1000, 8'b1001_0000,
                    8'b1001_0010, 8'b1001_0000, 8'b1001_0100, 8'b1000_0100, 8'b1000_0100,
                    8'b1001_0000, 8'b0000_0000};
        for (int i = 0; i < 12; i++) begin
            press(seq_btn[i]);
            vectors++; if (outs !== seq_exp[i]) begin miscompares++;
                $display("FAIL watch_step%0d: got %b want %b", i, outs, seq_exp[i]); end
        end
    endtask

    task automatic test_pc();
`ifdef PC_CMD_EN
        btn_clear = 1'b1;
        tick();
        btn_clear = 1'b0;
        pc_valid  = 1'b1;
        pc_cmd    = 8'h72;
        vectors++; if (pc_ready !== 1'b0) begin miscompares++;
            $display("FAIL pc_busy_edge: got %b want %b", pc_ready, 1'b0); end
        tick();
        vectors++; if ({outs, pc_ready} !== 9'b0010_0000_0) begin miscompares++;
            $display("FAIL pc_busy_clr: got %b want %b", {outs, pc_ready}, 9'b0010_0000_0); end
        tick();
        vectors++; if ({outs, pc_ready} !== 9'b0000_0000_1) begin miscompares++;
            $display("FAIL pc_held: got %b want %b", {outs, pc_ready}, 9'b0000_0000_1); end
        tick();
        pc_valid = 1'b0;
        vectors++; if (outs !== 8'b0100_0000) begin miscompares++;
            $display("FAIL pc_run: got %b want %b", outs, 8'b0100_0000); end
        pc_send(8'h78);
        vectors++; if (outs !== 8'b0100_0001) begin miscompares++;
            $display("FAIL pc_err: got %b want %b", outs, 8'b0100_0001); end
        tick();
        vectors++; if (outs !== 8'b0100_0000) begin miscompares++;
            $display("FAIL pc_err_end: got %b want %b", outs, 8'b0100_0000); end
        pc_send(8'h72);
        pc_send(8'h6d);
        vectors++; if (outs !== 8'b1000_0000) begin miscompares++;
            $display("FAIL pc_mode: got %b want %b", outs, 8'b1000_0000); end
        pc_send(8'h64);
        pc_send(8'h64);
        pc_send(8'h75);
        vectors++; if (outs !== 8'b1001_0110) begin miscompares++;
            $display("FAIL pc_up: got %b want %b", outs, 8'b1001_0110); end
        pc_send(8'h6d);
        vectors++; if (outs !== 8'b0000_0100) begin miscompares++;
            $display("FAIL pc_back: got %b want %b", outs, 8'b0000_0100); end
`else
        pc_valid = 1'b1;
        pc_cmd   = 8'h72;
        tick();
        vectors++; if ({outs, pc_ready} !== 9'b0000_0000_0) begin miscompares++;
            $display("FAIL nopc_r: got %b want %b", {outs, pc_ready}, 9'b0000_0000_0); end
        pc_cmd = 8'h78;
        tick();
        tick();
        vectors++; if ({outs, pc_ready} !== 9'b0000_0000_0) begin miscompares++;
            $display("FAIL nopc_x: got %b want %b", {outs, pc_ready}, 9'b0000_0000_0); end
        pc_valid = 1'b0;
`endif
    endtask

    task automatic test_reset_mid();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        press(B_MODE);
        press(B_DIG);
        press(B_DIG);
        press(B_DIG);
        vectors++; if (outs !== 8'b1001_1000) begin miscompares++;
            $display("FAIL rmid_setup: got %b want %b", outs, 8'b1001_1000); end
        btn_up = 1'b1;
        tick();
        rst = 1'b1;
        #1;
        vectors++; if ({outs, pc_ready} !== 9'b0000_0000_0) begin miscompares++;
            $display("FAIL rmid_rst: got %b want %b", {outs, pc_ready}, 9'b0000_0000_0); end
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++; if (outs !== 8'b0000_0000) begin miscompares++;
                $display("FAIL rmid_held%0d: got %b want %b", i, outs, 8'b0000_0000); end
        end
        btn_up = 1'b0;
        tick();
        press(B_CLR);
        rst = 1'b1;
        #1;
        vectors++; if (outs !== 8'b0000_0000) begin miscompares++;
            $display("FAIL rclr_rst: got %b want %b", outs, 8'b0000_0000); end
        tick();
        rst = 1'b0;
        tick();
        press(B_RUN);
        vectors++; if (outs !== 8'b0100_0000) begin miscompares++;
            $display("FAIL rclr_after: got %b want %b", outs, 8'b0100_0000); end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        {btn_clear, btn_run, btn_mode, btn_digit, btn_up} = 5'b0;
        pc_valid    = 1'b0;
        pc_cmd      = 8'h00;
        test_reset();
        test_run();
        test_clear();
        test_level();
        test_watch();
        test_pc();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
